// File: rtl/menu_pkg.sv
// Shared definitions for the menu controller: character codes, the item text table
// and the selection FSM state type.
package menu_pkg;

  localparam logic [3:0] CHAR_B     = 4'd10;
  localparam logic [3:0] CHAR_F     = 4'd11;
  localparam logic [3:0] CHAR_I     = 4'd12;
  localparam logic [3:0] CHAR_U     = 4'd13;
  localparam logic [3:0] CHAR_Z     = 4'd14;
  localparam logic [3:0] CHAR_BLANK = 4'd15;

  localparam logic [31:0] BLANK_LINE = {8{CHAR_BLANK}};

  // Nibble 0 is the leftmost character, so each string is written right-to-left.
  localparam logic [31:0] ITEM0 = {{4{CHAR_BLANK}}, CHAR_Z, CHAR_Z, CHAR_I, CHAR_F};          // "FIZZ"
  localparam logic [31:0] ITEM1 = {{4{CHAR_BLANK}}, CHAR_Z, CHAR_Z, CHAR_U, CHAR_B};          // "BUZZ"
  localparam logic [31:0] ITEM2 = {{3{CHAR_BLANK}}, 4'd2, CHAR_BLANK, CHAR_F, CHAR_U, CHAR_B}; // "BUF 2"
  localparam logic [31:0] ITEM3 = {{3{CHAR_BLANK}}, 4'd3, CHAR_BLANK, CHAR_B, CHAR_I, CHAR_F}; // "FIB 3"

  localparam logic [3:0][31:0] ITEM = {ITEM3, ITEM2, ITEM1, ITEM0};

  typedef enum logic [1:0] {
    BROWSE  = 2'd0,
    CONFIRM = 2'd1,
    RELEASE = 2'd2
  } menu_state_e;

endpackage

// File: rtl/menu_if.sv
// Menu controller bus: renderer scan timing in, text/origin out, buttons in,
// selection strobe and FSM debug view out.
interface menu_if;
  import menu_pkg::*;

  logic        newframe;
  logic        newline;
  logic [9:0]  y;
  logic        btn_up;
  logic        btn_down;
  logic        btn_sel;
  logic [31:0] line;
  logic [9:0]  x0;
  logic [9:0]  y0;
  logic        hilite;
  // sel_valid is a bare one-cycle strobe with no ready: the consumer must take
  // sel_idx in the cycle sel_valid is high, there is no back-pressure.
  logic        sel_valid;
  logic [1:0]  sel_idx;
  menu_state_e state;
  logic [1:0]  cursor;

  modport master (
    output newframe, newline, y, btn_up, btn_down, btn_sel,
    input  line, x0, y0, hilite, sel_valid, sel_idx, state, cursor
  );

  modport slave (
    input  newframe, newline, y, btn_up, btn_down, btn_sel,
    output line, x0, y0, hilite, sel_valid, sel_idx, state, cursor
  );
endinterface

// File: rtl/btn_debounce.sv
// Frame-rate debouncer: the level follows raw only after DEB_FRAMES consecutive
// newframe samples that disagree with it.
module btn_debounce #(
  parameter int DEB_FRAMES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic newframe,
  input  logic raw,
  output logic press,
  output logic level_next
);
  localparam int CW = $clog2(DEB_FRAMES + 1);

  logic          level;
  logic [CW-1:0] cnt;
  logic          flip;

  // press and level_next are combinational so the FSM consumes them on the same newframe.
  always_comb begin
    flip       = newframe && (raw != level) && (cnt == CW'(DEB_FRAMES - 1));
    level_next = flip ? raw : level;
    press      = flip && raw;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (newframe) begin
      if (raw == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= raw;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/menu_ctrl.sv
// Menu controller: time-shares one text renderer across N_ITEMS rows and runs the
// browse/confirm/release selection FSM from debounced buttons.
module menu_ctrl
  import menu_pkg::*;
#(
  parameter int N_ITEMS      = 4,
  parameter int X_BASE       = 400,
  parameter int Y_BASE       = 50,
  parameter int ROW_PITCH    = 24,
  parameter int DEB_FRAMES   = 3,
  parameter int BLINK_FRAMES = 16
) (
  input  logic clk,
  input  logic rst,
  menu_if.slave bus
);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  menu_state_e    state;
  logic [1:0]     cursor;
  logic [BW-1:0]  blink_cnt;
  logic           blink_phase;
  logic [31:0]    line_q;
  logic [9:0]     x0_q;
  logic [9:0]     y0_q;
  logic           hilite_q;
  logic           sel_valid_q;
  logic [1:0]     sel_idx_q;

  logic up_press, down_press, sel_press;
  logic up_lvl_nx, down_lvl_nx, sel_lvl_nx;
  logic       row_hit;
  logic [1:0] row_slot;
  logic [9:0] row_y;

  btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_up (
    .clk(clk), .rst(rst), .newframe(bus.newframe), .raw(bus.btn_up),
    .press(up_press), .level_next(up_lvl_nx)
  );
  btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_down (
    .clk(clk), .rst(rst), .newframe(bus.newframe), .raw(bus.btn_down),
    .press(down_press), .level_next(down_lvl_nx)
  );
  btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_sel (
    .clk(clk), .rst(rst), .newframe(bus.newframe), .raw(bus.btn_sel),
    .press(sel_press), .level_next(sel_lvl_nx)
  );

  // Row lookup by range compare against each row's constant bounds.
  always_comb begin
    row_hit  = 1'b0;
    row_slot = 2'd0;
    row_y    = 10'(Y_BASE);
    for (int k = 0; k < N_ITEMS; k++) begin
      if (int'(bus.y) >= Y_BASE + k * ROW_PITCH &&
          int'(bus.y) <  Y_BASE + (k + 1) * ROW_PITCH) begin
        row_hit  = 1'b1;
        row_slot = 2'(k);
        row_y    = 10'(Y_BASE + k * ROW_PITCH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= BROWSE;
      cursor      <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      line_q      <= BLANK_LINE;
      x0_q        <= 10'(X_BASE);
      y0_q        <= 10'(Y_BASE);
      hilite_q    <= 1'b0;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= 2'd0;
    end else begin
      if (bus.newline) begin
        if (row_hit) begin
          line_q   <= ITEM[row_slot];
          x0_q     <= 10'(X_BASE);
          y0_q     <= row_y;
          hilite_q <= (row_slot == cursor) && ((state != RELEASE) || blink_phase);
        end else begin
          line_q   <= BLANK_LINE;
          hilite_q <= 1'b0;
        end
      end

      sel_valid_q <= 1'b0;
      case (state)
        BROWSE: begin
          if (bus.newframe) begin
            if (sel_press) begin
              state       <= CONFIRM;
              sel_valid_q <= 1'b1;
              sel_idx_q   <= cursor;
            end else if (up_press && !down_press) begin
              cursor <= (cursor == 2'd0) ? 2'(N_ITEMS - 1) : cursor - 2'd1;
            end else if (down_press && !up_press) begin
              cursor <= (cursor == 2'(N_ITEMS - 1)) ? 2'd0 : cursor + 2'd1;
            end
          end
        end
        CONFIRM: begin
          state       <= RELEASE;
          blink_cnt   <= '0;
          blink_phase <= 1'b1;
        end
        RELEASE: begin
          if (bus.newframe) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
              blink_cnt   <= '0;
              blink_phase <= ~blink_phase;
            end else begin
              blink_cnt <= blink_cnt + BW'(1);
            end
            if (!up_lvl_nx && !down_lvl_nx && !sel_lvl_nx) state <= BROWSE;
          end
        end
        default: state <= BROWSE;
      endcase
    end
  end

  assign bus.line      = line_q;
  assign bus.x0        = x0_q;
  assign bus.y0        = y0_q;
  assign bus.hilite    = hilite_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.sel_idx   = sel_idx_q;
  assign bus.state     = state;
  assign bus.cursor    = cursor;
endmodule

// File: tb/tb_menu_ctrl.sv
// Directed bench for menu_ctrl: row scan, debounce, wrap, select/release, blink
// and reset abort, with a strobe scoreboard on sel_valid.
module tb_menu_ctrl;
  import menu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  menu_if bus();

  menu_ctrl #(
    .N_ITEMS(4), .X_BASE(400), .Y_BASE(50), .ROW_PITCH(24),
    .DEB_FRAMES(3), .BLINK_FRAMES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  localparam logic [31:0] L_BLANK = 32'hFFFF_FFFF;
  localparam logic [31:0] L_FIZZ  = 32'hFFFF_EECB;
  localparam logic [31:0] L_BUZZ  = 32'hFFFF_EEDA;
  localparam logic [31:0] L_BUF2  = 32'hFFF2_FBDA;
  localparam logic [31:0] L_FIB3  = 32'hFFF3_FACB;

  int n_checks = 0;
  int n_errors = 0;
  int sel_seen = 0;
  int sel_total = 0;
  logic [1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every sel_valid cycle must match the next expected index.
  always @(negedge clk) begin
    if (bus.sel_valid === 1'b1) begin
      sel_seen++;
      if (exp_q.size() > 0) check_eq("sel_idx", 32'(bus.sel_idx), 32'(exp_q.pop_front()));
    end
  end

  task automatic frame();
    @(negedge clk); bus.newframe = 1'b1;
    @(negedge clk); bus.newframe = 1'b0;
  endtask

  task automatic scan(input logic [9:0] yy);
    @(negedge clk); bus.y = yy; bus.newline = 1'b1;
    @(negedge clk); bus.newline = 1'b0;
  endtask

  task automatic check_scan(input string tag, input logic [9:0] yy, input logic [31:0] exp_line,
                            input int exp_y0, input logic exp_hl);
    scan(yy);
    check_eq({tag, "_line"}, bus.line, exp_line);
    check_eq({tag, "_y0"}, 32'(bus.y0), 32'(exp_y0));
    check_eq({tag, "_hilite"}, 32'(bus.hilite), 32'(exp_hl));
  endtask

  task automatic press(input logic u, input logic d, input logic s);
    bus.btn_up = u; bus.btn_down = d; bus.btn_sel = s;
    repeat (3) frame();
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_sel = 1'b0;
    repeat (3) frame();
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_line"}, bus.line, L_BLANK);
    check_eq({tag, "_x0"}, 32'(bus.x0), 32'd400);
    check_eq({tag, "_y0"}, 32'(bus.y0), 32'd50);
    check_eq({tag, "_hilite"}, 32'(bus.hilite), 32'd0);
    check_eq({tag, "_sel_valid"}, 32'(bus.sel_valid), 32'd0);
    check_eq({tag, "_sel_idx"}, 32'(bus.sel_idx), 32'd0);
    check_eq({tag, "_cursor"}, 32'(bus.cursor), 32'd0);
    check_eq({tag, "_state"}, 32'(bus.state), 32'(BROWSE));
  endtask

  initial begin
    bus.newframe = 1'b0; bus.newline = 1'b0; bus.y = 10'd0;
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_sel = 1'b0;

    // Clock/reset
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;

    // Row scan and band edges
    check_scan("row0", 10'd50, L_FIZZ, 50, 1'b1);
    check_eq("row0_x0", 32'(bus.x0), 32'd400);
    check_scan("row1", 10'd74, L_BUZZ, 74, 1'b0);
    check_scan("below", 10'd146, L_BLANK, 74, 1'b0);
    check_scan("above", 10'd49, L_BLANK, 74, 1'b0);
    check_scan("row3_last", 10'd145, L_FIB3, 122, 1'b0);
    check_scan("row1_last", 10'd97, L_BUZZ, 74, 1'b0);
    check_scan("row2_first", 10'd98, L_BUF2, 98, 1'b0);

    // Debounce: two high samples are not enough, three are
    bus.btn_down = 1'b1; frame(); frame();
    bus.btn_down = 1'b0; repeat (3) frame();
    check_eq("deb_short", 32'(bus.cursor), 32'd0);
    bus.btn_down = 1'b1; frame(); frame();
    check_eq("deb_2of3", 32'(bus.cursor), 32'd0);
    frame();
    check_eq("deb_3rd", 32'(bus.cursor), 32'd1);
    frame(); frame();
    check_eq("deb_hold", 32'(bus.cursor), 32'd1);
    bus.btn_down = 1'b0; repeat (3) frame();

    // Wrap and simultaneous up/down
    press(1'b1, 1'b0, 1'b0);
    check_eq("up_1to0", 32'(bus.cursor), 32'd0);
    press(1'b1, 1'b0, 1'b0);
    check_eq("wrap_up", 32'(bus.cursor), 32'd3);
    press(1'b0, 1'b1, 1'b0);
    check_eq("wrap_down", 32'(bus.cursor), 32'd0);
    press(1'b1, 1'b1, 1'b0);
    check_eq("up_down_same", 32'(bus.cursor), 32'd0);

    // newframe and newline in the same cycle
    bus.btn_down = 1'b1; frame(); frame();
    @(negedge clk); bus.newframe = 1'b1; bus.newline = 1'b1; bus.y = 10'd74;
    @(negedge clk); bus.newframe = 1'b0; bus.newline = 1'b0;
    check_eq("both_cursor", 32'(bus.cursor), 32'd1);
    check_eq("both_line", bus.line, L_BUZZ);
    check_eq("both_y0", 32'(bus.y0), 32'd74);
    bus.btn_down = 1'b0; repeat (3) frame();

    // Select at cursor 2
    press(1'b0, 1'b1, 1'b0);
    check_eq("sel_cursor", 32'(bus.cursor), 32'd2);
    exp_q.push_back(2'd2); sel_total++;
    bus.btn_sel = 1'b1;
    repeat (3) frame();
    check_eq("confirm_state", 32'(bus.state), 32'(CONFIRM));
    check_eq("confirm_valid", 32'(bus.sel_valid), 32'd1);
    check_eq("confirm_idx", 32'(bus.sel_idx), 32'd2);
    @(negedge clk);
    check_eq("release_state", 32'(bus.state), 32'(RELEASE));
    check_eq("release_valid", 32'(bus.sel_valid), 32'd0);

    // Blink on row 2 while sel is held
    for (int f = 0; f < 32; f++) begin
      scan(10'd98);
      check_eq($sformatf("blink_f%0d", f), 32'(bus.hilite), (f < 16) ? 32'd1 : 32'd0);
      frame();
    end
    check_scan("release_row0", 10'd50, L_FIZZ, 50, 1'b0);
    for (int f = 32; f < 100; f++) begin
      if (f == 40) bus.btn_down = 1'b1;
      if (f == 60) bus.btn_down = 1'b0;
      frame();
    end
    check_eq("hold_state", 32'(bus.state), 32'(RELEASE));
    check_eq("hold_cursor", 32'(bus.cursor), 32'd2);
    bus.btn_sel = 1'b0;
    frame(); check_eq("rel_f1", 32'(bus.state), 32'(RELEASE));
    frame(); check_eq("rel_f2", 32'(bus.state), 32'(RELEASE));
    frame(); check_eq("rel_f3", 32'(bus.state), 32'(BROWSE));

    // Reset during CONFIRM
    press(1'b0, 1'b1, 1'b0);
    check_eq("pre_rst_cursor", 32'(bus.cursor), 32'd3);
    exp_q.push_back(2'd3); sel_total++;
    bus.btn_sel = 1'b1;
    repeat (3) frame();
    check_eq("rst_confirm_state", 32'(bus.state), 32'(CONFIRM));
    rst = 1'b0; bus.btn_sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_reset_state("rst_confirm");
    repeat (4) frame();
    check_eq("post_rst_state", 32'(bus.state), 32'(BROWSE));

    // Reset during RELEASE
    exp_q.push_back(2'd0); sel_total++;
    bus.btn_sel = 1'b1;
    repeat (3) frame();
    @(negedge clk);
    check_eq("rst_release_pre", 32'(bus.state), 32'(RELEASE));
    frame();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; bus.btn_sel = 1'b0;
    check_eq("rst_release_state", 32'(bus.state), 32'(BROWSE));
    check_eq("rst_release_valid", 32'(bus.sel_valid), 32'd0);
    repeat (4) frame();

    check_eq("sel_pulses", 32'(sel_seen), 32'(sel_total));
    check_eq("sel_pending", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/menu_ctrl.md
MENU_CTRL -- requirements
Module: menu_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- N_ITEMS, 4, menu entries (2..4).
- X_BASE, 400, menu left column in pixels.
- Y_BASE, 50, first row top in pixels.
- ROW_PITCH, 24, vertical distance between rows in pixels.
- DEB_FRAMES, 3, consecutive frames a button must be stable.
- BLINK_FRAMES, 16, highlight toggle period in frames.

REQ-002 The block SHALL have these ports, one clock, reset synchronous active-low:
- clk  in  1  pixel clock, the same clock as the text ROM renderer.
- rst  in  1  synchronous, active-low reset.
- newframe  in  1  one-cycle frame-start pulse.
- newline  in  1  one-cycle line-start pulse.
- y  in  10  scanline about to be drawn, valid while newline=1.
- btn_up, btn_down, btn_sel  in  1 each  raw buttons, already synchronous to clk, active-high.
- line  out  32  eight 4-bit char codes; nibble 0 is the leftmost character.
- x0, y0  out  10 each  renderer origin.
- hilite  out  1  current row is the cursor row.
- sel_valid  out  1  one-cycle selection strobe.
- sel_idx  out  2  selected item, valid with sel_valid.

Function
REQ-003 The block SHALL time-share one text renderer between N_ITEMS rows; row k occupies y in [Y_BASE+k*ROW_PITCH, Y_BASE+(k+1)*ROW_PITCH).
REQ-004 The block SHALL find the row slot from y sampled while newline=1, using comparators only, with no divider.
REQ-005 line, y0 and hilite SHALL update on the clk edge after newline=1 and hold until the next newline.
REQ-006 Inside the band, the outputs SHALL be: line=ITEM[k], y0=Y_BASE+k*ROW_PITCH, x0=X_BASE.
REQ-007 Outside the band (y<Y_BASE or y>=Y_BASE+N_ITEMS*ROW_PITCH), the outputs SHALL be: line=all CHAR_BLANK, hilite=0, y0 held.
REQ-008 Each button SHALL be debounced by sampling only at newframe; the debounced level changes after DEB_FRAMES consecutive equal samples.
REQ-009 A press event SHALL be the 0->1 edge of a debounced level, consumed on the same newframe.
REQ-010 The FSM states SHALL be BROWSE, CONFIRM and RELEASE.
REQ-011 In BROWSE, an up event SHALL decrement the cursor, wrapping 0->N_ITEMS-1.
REQ-012 In BROWSE, a down event SHALL increment the cursor, wrapping N_ITEMS-1->0.
REQ-013 Up and down events arriving on the same newframe SHALL be ignored.
REQ-014 A sel event SHALL take priority over up/down; the FSM SHALL then go to CONFIRM.
REQ-015 The cursor SHALL change only at newframe, so no frame tears.
REQ-016 CONFIRM SHALL last exactly one clk: sel_valid=1, sel_idx=cursor, then the FSM SHALL go to RELEASE.
REQ-017 RELEASE SHALL ignore all events and return to BROWSE at the first newframe where all three debounced levels are 0.
REQ-018 hilite SHALL be 1 when the row slot equals the cursor; in RELEASE it SHALL additionally be ANDed with a blink phase that toggles every BLINK_FRAMES newframes.
REQ-019 The blink counter SHALL clear on entry to RELEASE, so the phase starts at 1.
REQ-020 If newframe and newline are high in the same cycle, both SHALL be processed in that cycle.

Reset
REQ-021 While rst=0 at a clk edge, the block SHALL load:
- line=all CHAR_BLANK, x0=X_BASE, y0=Y_BASE.
- hilite=0, sel_valid=0, sel_idx=0.
- cursor=0, state=BROWSE.
- debounce counters and levels=0, blink counter=0.
REQ-022 Reset asserted mid-CONFIRM or mid-RELEASE SHALL abort the selection with no sel_valid pulse.

Structure
REQ-023 Package menu_pkg SHALL hold:
- char codes 0-9 digits, B=10, F=11, I=12, U=13, Z=14, BLANK=15;
- the ITEM string table, 32 bits per entry;
- the FSM state type.
REQ-024 Sub-module btn_debounce (level and counter per button) SHALL be instantiated three times.

Verification
REQ-025 Row scan: newline with y=50 -> line=ITEM[0], y0=50. y=74 -> ITEM[1], y0=74. y=146 -> all blank, y0 stays 74.
REQ-026 Debounce: btn_down high for 2 newframes, then low -> cursor stays 0. High for 3 newframes -> cursor=1 on the 3rd.
REQ-027 Wrap: up press at cursor=0 -> cursor=3. Down press at cursor=3 -> cursor=0. Up+down on the same frame -> unchanged.
REQ-028 Select: cursor=2, sel press -> exactly one clk of sel_valid with sel_idx=2. Hold sel 100 frames -> no further pulse. Release -> BROWSE after 3 frames.
REQ-029 Blink: in RELEASE with y in row 2 -> hilite 1 for frames 0-15, 0 for 16-31.
REQ-030 Reset: rst=0 during CONFIRM -> sel_valid=0 and all REQ-021 values on the next edge.
